// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data ports: grant, one mem_en strobe, capture after LATENCY,
// one-cycle valid (request-to-valid LATENCY+2); requesters are stalled while their req is high and valid is low.
module mem_port_arbiter #(
    parameter int LATENCY      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    output logic        stall_if,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        stall_mem,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] cnt_if_grants,
    output logic [31:0] cnt_d_grants,
    output logic [31:0] cnt_conflicts
);

    localparam int LCW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int SCW = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
    localparam logic [LCW-1:0] LAT_LOAD   = LCW'(LATENCY - 1);
    localparam logic [SCW-1:0] STREAK_MAX = SCW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t         state;
    state_t         state_nxt;
    logic           owner_d;
    logic           own_we;
    logic [LCW-1:0] lat_cnt;
    logic [SCW-1:0] streak;
    logic           if_elig;
    logic           d_elig;
    logic           grant_if;
    logic           grant_d;
    logic           capture;

    assign if_valid  = (state == DONE) && !owner_d;
    assign d_valid   = (state == DONE) && owner_d;
    assign mem_en    = (state == ISSUE);
    assign mem_we    = own_we;
    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = d_req & ~d_valid;

    // A req seen in its own valid cycle belongs to the transaction just completed.
    assign if_elig = if_req & ~if_valid;
    assign d_elig  = d_req & ~d_valid;
    assign capture = (state == WAIT) && (lat_cnt == '0);

    always_comb begin
        grant_if  = 1'b0;
        grant_d   = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                // Data wins contention until it has starved fetch STARVE_LIMIT times in a row.
                if (d_elig && !(if_elig && (streak == STREAK_MAX))) begin
                    grant_d = 1'b1;
                end else if (if_elig) begin
                    grant_if = 1'b1;
                end
                if (grant_d || grant_if) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (lat_cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_d       <= 1'b0;
            own_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            if_rdata      <= '0;
            d_rdata       <= '0;
            lat_cnt       <= '0;
            streak        <= '0;
            cnt_if_grants <= '0;
            cnt_d_grants  <= '0;
            cnt_conflicts <= '0;
        end else begin
            if (grant_d) begin
                owner_d      <= 1'b1;
                own_we       <= d_we;
                mem_addr     <= d_addr;
                mem_wdata    <= d_wdata;
                cnt_d_grants <= cnt_d_grants + 32'd1;
                if (if_elig && (streak != STREAK_MAX)) begin
                    streak <= streak + 1'b1;
                end
            end
            if (grant_if) begin
                owner_d       <= 1'b0;
                own_we        <= 1'b0;
                mem_addr      <= if_addr;
                cnt_if_grants <= cnt_if_grants + 32'd1;
                streak        <= '0;
            end
            if ((state == IDLE) && if_elig && d_elig) begin
                cnt_conflicts <= cnt_conflicts + 32'd1;
            end
            if (state == ISSUE) begin
                lat_cnt <= LAT_LOAD;
            end else if ((state == WAIT) && (lat_cnt != '0)) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
            if (capture && !owner_d) begin
                if_rdata <= mem_rdata;
            end
            if (capture && owner_d && !own_we) begin
                d_rdata <= mem_rdata;
            end
        end
    end

endmodule
